// File: rtl/pipearch_common.sv
// Shared register map and CCI-P channel-0 types used by the pipearch load/store blocks.
package pipearch_common;

    localparam int NUM_REGS           = 8;
    localparam int REG_LOAD_SRC       = 3;
    localparam int REG_LOAD_LINES     = 4;
    localparam int REG_LOAD_BRAM_BASE = 5;

    typedef logic [41:0]  t_ccip_clAddr;
    typedef logic [15:0]  t_ccip_mdata;
    typedef logic [511:0] t_ccip_clData;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic [1:0]   cl_len;
        logic [3:0]   req_type;
        logic [5:0]   rsvd;
        t_ccip_clAddr address;
        t_ccip_mdata  mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        t_ccip_mdata mdata;
    } t_ccip_c0_RspMemHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c0_RspMemHdr hdr;
        t_ccip_clData       data;
        logic               rspValid;
        logic               mmioRdValid;
        logic               mmioWrValid;
    } t_if_ccip_c0_Rx;

    // Bit 31 picks in_addr over out_addr; the low 31 bits are a cache-line offset.
    function automatic t_ccip_clAddr load_src(input logic [31:0] r,
                                              input t_ccip_clAddr in_base,
                                              input t_ccip_clAddr out_base);
        t_ccip_clAddr base;
        base = r[31] ? in_base : out_base;
        return base + t_ccip_clAddr'(r[30:0]);
    endfunction

endpackage

// File: rtl/fifobram_interface.sv
// Write port bundle for a line-wide on-chip BRAM.
interface fifobram_interface #(
    parameter int DATA_W = 512,
    parameter int ADDR_W = 16
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    modport bram_write (output we, output waddr, output wdata);
    modport bram_sink  (input we, input waddr, input wdata);
endinterface

// File: rtl/glm_load.sv
// Streams L cache lines from host memory into a BRAM; responses may return in any
// order and are placed by their mdata tag.
module glm_load
    import pipearch_common::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           op_start,
    output logic           op_done,
    input  logic [31:0]    regs [NUM_REGS],
    input  t_ccip_clAddr   in_addr,
    input  t_ccip_clAddr   out_addr,
    fifobram_interface.bram_write MEM_dest,
    input  logic           c0TxAlmFull,
    input  t_if_ccip_c0_Rx cp2af_sRx_c0,
    output t_if_ccip_c0_Tx af2cp_sTx_c0
);

    typedef enum logic [1:0] {IDLE, REQUEST, DRAIN, DONE} state_t;

    state_t       state;
    t_ccip_clAddr src;
    logic [15:0]  num_lines;
    logic [15:0]  bram_base;
    logic [15:0]  num_req;
    logic [15:0]  num_rsp;

    // c0 handshake: a request is the single cycle af2cp_sTx_c0.valid is high, and is
    // only launched from an edge where c0TxAlmFull was low. Responses carry no
    // back-pressure: every rspValid cycle seen while a load is active is consumed.
    logic rsp_take;
    logic req_fire;
    logic last_rsp;

    assign rsp_take = cp2af_sRx_c0.rspValid && (state == REQUEST || state == DRAIN);
    assign req_fire = (state == REQUEST) && !c0TxAlmFull;
    assign last_rsp = rsp_take && (num_rsp == num_lines - 16'd1);

    logic [31:0] unused_regs;
    logic        unused_bits;

    always_comb begin
        unused_regs = '0;
        for (int i = 0; i < NUM_REGS; i++) unused_regs = unused_regs ^ regs[i];
    end
    assign unused_bits = ^{unused_regs, cp2af_sRx_c0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            src            <= '0;
            num_lines      <= '0;
            bram_base      <= '0;
            num_req        <= '0;
            num_rsp        <= '0;
            op_done        <= 1'b0;
            af2cp_sTx_c0   <= '0;
            MEM_dest.we    <= 1'b0;
            MEM_dest.waddr <= '0;
            MEM_dest.wdata <= '0;
        end else begin
            op_done      <= 1'b0;
            af2cp_sTx_c0 <= '0;
            MEM_dest.we  <= 1'b0;

            // Placement depends only on the returned tag, so ordering is irrelevant.
            if (rsp_take) begin
                MEM_dest.we    <= 1'b1;
                MEM_dest.waddr <= bram_base + cp2af_sRx_c0.hdr.mdata;
                MEM_dest.wdata <= cp2af_sRx_c0.data;
                num_rsp        <= num_rsp + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (op_start) begin
                        src       <= load_src(regs[REG_LOAD_SRC], in_addr, out_addr);
                        num_lines <= regs[REG_LOAD_LINES][15:0];
                        bram_base <= regs[REG_LOAD_BRAM_BASE][15:0];
                        num_req   <= '0;
                        num_rsp   <= '0;
                        state     <= (regs[REG_LOAD_LINES][15:0] == 16'd0) ? DONE : REQUEST;
                    end
                end
                REQUEST: begin
                    if (req_fire) begin
                        af2cp_sTx_c0.valid       <= 1'b1;
                        af2cp_sTx_c0.hdr.address <= src + t_ccip_clAddr'(num_req);
                        af2cp_sTx_c0.hdr.mdata   <= num_req;
                        num_req                  <= num_req + 16'd1;
                        if (num_req == num_lines - 16'd1) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_rsp) state <= DONE;
                end
                DONE: begin
                    op_done <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
